// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: bus widths and the DMA copy-engine FSM encoding.
package cpu16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Data-memory port bundle between the copy engine (master) and DataMemory (slave).
interface dma_copy_engine_if #(
  parameter int ADDR_W = cpu16_pkg::ADDR_W,
  parameter int DATA_W = cpu16_pkg::DATA_W
);

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write,
    output mem_read,
    input  mem_read_data
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write,
    input  mem_read,
    output mem_read_data
  );

endinterface

// File: rtl/dma_copy_engine.sv
// Memory-to-memory block copy engine: one READ cycle then one WRITE cycle per word,
// ascending addresses with modulo-2^ADDR_W wrap. Memory outputs are decoded from
// registered state only, so start/abort never reach the memory port combinationally.
// ADDR_W/DATA_W must match the widths of the connected interface instance.
module dma_copy_engine #(
  parameter int ADDR_W = cpu16_pkg::ADDR_W,
  parameter int DATA_W = cpu16_pkg::DATA_W,
  parameter int LEN_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [LEN_W-1:0]   length,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  dma_copy_engine_if.master  mem
);

  import cpu16_pkg::*;

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              aborted_q, aborted_d;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic: accept only in IDLE, abort only honoured in READ/WRITE.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    aborted_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d       = src_addr;
            dst_d       = dst_addr;
            remaining_d = length;
            state_d     = READ;
          end else begin
            state_d = FINISH;
          end
        end
      end
      READ: begin
        hold_d = mem.mem_read_data;
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The write itself still lands this cycle even when aborting.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          src_d       = src_q + ADDR_W'(1);
          dst_d       = dst_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          state_d     = (remaining_q == LEN_W'(1)) ? FINISH : READ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-port and status outputs decoded purely from registered state.
  always_comb begin
    mem.mem_read       = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_address    = '0;
    mem.mem_write_data = '0;
    case (state_q)
      READ: begin
        mem.mem_read    = 1'b1;
        mem.mem_address = src_q;
      end
      WRITE: begin
        mem.mem_write      = 1'b1;
        mem.mem_address    = dst_q;
        mem.mem_write_data = hold_q;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: behavioural DataMemory, write scoreboard,
// and per-copy cycle statistics compared against the documented timing.
module tb_dma_copy_engine;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;

  dma_copy_engine_if bus ();

  dma_copy_engine dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .mem      (bus.master)
  );

  // Behavioural DataMemory: combinational read, write on the rising edge.
  logic [15:0] mem [0:65535];
  assign bus.mem_read_data = mem[bus.mem_address];
  always @(posedge clock) begin
    if (bus.mem_write) mem[bus.mem_address] = bus.mem_write_data;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int start_cyc = 0;
  int n_reads, n_writes, done_cnt, done_cyc, busy_cnt, busy_first, busy_last;
  int aborted_cnt, aborted_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_writes = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    aborted_cnt = 0; aborted_cyc = -1;
  endtask

  // Monitor: sample away from the active edge, pop the scoreboard on each write.
  int rel;
  always @(negedge clock) begin
    if (reset_n) begin
      rel = cyc - start_cyc + 1;
      if (bus.mem_read && bus.mem_write) check_eq("rd_wr_excl", 1, 0);
      if (bus.mem_read) n_reads++;
      if (bus.mem_write) begin
        wr_t e;
        n_writes++;
        check_eq("wr_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("wr_addr", bus.mem_address, e.addr);
          check_eq("wr_data", bus.mem_write_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = rel;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (aborted) begin
        aborted_cnt++;
        if (aborted_cyc < 0) aborted_cyc = rel;
      end
    end
  end

  // Push expected writes for words [0, nwords) of a copy, from the bench's own memory image.
  task automatic push_expected(input logic [15:0] s, input logic [15:0] d, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      wr_t e;
      e.addr = 16'(d + i);
      e.data = mem[16'(s + i)];
      exp_q.push_back(e);
    end
  endtask

  // Drive start during cycle -1 so it is accepted at edge 0; returns #1 into cycle 1.
  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(posedge clock); #1;
    clear_stats();
    start_cyc = cyc + 1;
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    @(posedge clock); #1;
    start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_aborted"}, aborted, 0);
    check_eq({pfx, "_mem_read"}, bus.mem_read, 0);
    check_eq({pfx, "_mem_write"}, bus.mem_write, 0);
    check_eq({pfx, "_mem_address"}, bus.mem_address, 0);
    check_eq({pfx, "_mem_wdata"}, bus.mem_write_data, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    wait_cycles(2);
    check_outputs_zero("idle");

    // Copy N=3
    mem[12] = 16'h0012; mem[13] = 16'h0034; mem[14] = 16'h0056;
    push_expected(16'd12, 16'd40, 3);
    start_copy(16'd12, 16'd40, 16'd3);
    wait_cycles(9);
    check_eq("n3_mem40", mem[40], 16'h0012);
    check_eq("n3_mem41", mem[41], 16'h0034);
    check_eq("n3_mem42", mem[42], 16'h0056);
    check_eq("n3_done_cyc", done_cyc, 7);
    check_eq("n3_done_cnt", done_cnt, 1);
    check_eq("n3_busy_first", busy_first, 1);
    check_eq("n3_busy_last", busy_last, 7);
    check_eq("n3_busy_cnt", busy_cnt, 7);
    check_eq("n3_reads", n_reads, 3);
    check_eq("n3_writes", n_writes, 3);
    check_eq("n3_queue_left", exp_q.size(), 0);

    // Zero length
    start_copy(16'd50, 16'd60, 16'd0);
    wait_cycles(4);
    check_eq("n0_done_cyc", done_cyc, 1);
    check_eq("n0_done_cnt", done_cnt, 1);
    check_eq("n0_busy_cnt", busy_cnt, 1);
    check_eq("n0_busy_first", busy_first, 1);
    check_eq("n0_reads", n_reads, 0);
    check_eq("n0_writes", n_writes, 0);

    // Address wrap-around
    mem[16'hFFFF] = 16'hAAAA; mem[16'h0000] = 16'hBBBB;
    push_expected(16'hFFFF, 16'h0100, 2);
    start_copy(16'hFFFF, 16'h0100, 16'd2);
    wait_cycles(7);
    check_eq("wrap_mem0100", mem[16'h0100], 16'hAAAA);
    check_eq("wrap_mem0101", mem[16'h0101], 16'hBBBB);
    check_eq("wrap_done_cyc", done_cyc, 5);
    check_eq("wrap_queue_left", exp_q.size(), 0);

    // Abort during WRITE of word 1 (cycle 4)
    for (int i = 0; i < 4; i++) begin
      mem[16'd100 + 16'(i)] = 16'h1100 + 16'(i);
      mem[16'd200 + 16'(i)] = 16'hDEAD;
    end
    push_expected(16'd100, 16'd200, 2);
    start_copy(16'd100, 16'd200, 16'd4);
    wait_cycles(3);
    abort = 1'b1;
    wait_cycles(1);
    abort = 1'b0;
    wait_cycles(8);
    check_eq("abort_mem200", mem[200], 16'h1100);
    check_eq("abort_mem201", mem[201], 16'h1101);
    check_eq("abort_mem202", mem[202], 16'hDEAD);
    check_eq("abort_mem203", mem[203], 16'hDEAD);
    check_eq("abort_pulse_cyc", aborted_cyc, 5);
    check_eq("abort_pulse_cnt", aborted_cnt, 1);
    check_eq("abort_done_cnt", done_cnt, 0);
    check_eq("abort_writes", n_writes, 2);
    check_eq("abort_queue_left", exp_q.size(), 0);

    // Start ignored while busy
    mem[300] = 16'h3000; mem[301] = 16'h3001;
    mem[500] = 16'h5000; mem[600] = 16'hBEEF;
    push_expected(16'd300, 16'd400, 2);
    start_copy(16'd300, 16'd400, 16'd2);
    start = 1'b1; src_addr = 16'd500; dst_addr = 16'd600; length = 16'd5;
    wait_cycles(1);
    start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    wait_cycles(14);
    check_eq("ign_mem400", mem[400], 16'h3000);
    check_eq("ign_mem401", mem[401], 16'h3001);
    check_eq("ign_mem600", mem[600], 16'hBEEF);
    check_eq("ign_done_cyc", done_cyc, 5);
    check_eq("ign_done_cnt", done_cnt, 1);
    check_eq("ign_busy_cnt", busy_cnt, 5);
    check_eq("ign_writes", n_writes, 2);
    check_eq("ign_queue_left", exp_q.size(), 0);

    // Asynchronous reset mid-READ
    mem[700] = 16'h7000; mem[701] = 16'h7001; mem[800] = 16'hCAFE;
    start_copy(16'd700, 16'd800, 16'd2);
    check_eq("rst_pre_read", bus.mem_read, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    wait_cycles(2);
    clear_stats();
    reset_n = 1'b1;
    wait_cycles(6);
    check_eq("rst_after_busy", busy_cnt, 0);
    check_eq("rst_after_done", done_cnt, 0);
    check_eq("rst_after_aborted", aborted_cnt, 0);
    check_eq("rst_mem800", mem[800], 16'hCAFE);
    mem[900] = 16'h9009;
    push_expected(16'd900, 16'd950, 1);
    start_copy(16'd900, 16'd950, 16'd1);
    wait_cycles(5);
    check_eq("rst_fresh_mem950", mem[950], 16'h9009);
    check_eq("rst_fresh_done_cyc", done_cyc, 3);
    check_eq("rst_fresh_queue_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
